ttl_updn_counter_chain_sync: RTL and testbench
==============================================

TTL_UPDN_COUNTER_CHAIN_SYNC -- requirements
Module: ttl_updn_counter_chain_sync

Interface
REQ-001 SHALL have parameter STAGES, default 2: number of cascaded 4-bit stages (1..8).
REQ-002 SHALL have parameter BCD, default 0: 0 = each stage counts 0..15; 1 = each stage counts 0..9 (decade).
REQ-003 SHALL have port Clk, input, 1: sole system clock; all state changes on posedge Clk.
REQ-004 SHALL have port Reset_bar, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port Cen, input, 1: count strobe; a rising edge sampled in the Clk domain is one count tick.
REQ-006 SHALL have port Clear_bar, input, 1: synchronous clear, active-low, applied on a tick.
REQ-007 SHALL have port Load_bar, input, 1: synchronous parallel load, active-low, applied on a tick.
REQ-008 SHALL have ports ENT and ENP, input, 1 each: both high enable counting; ENT also gates RCO.
REQ-009 SHALL have port Up_Dn, input, 1: 1 = count up, 0 = count down; sampled only on a tick.
REQ-010 SHALL have port D, input, 4*STAGES: load value, stage 0 in D[3:0].
REQ-011 SHALL have port Q, output, 4*STAGES: count value, stage 0 in Q[3:0].
REQ-012 SHALL have port Stage_TC, output, STAGES: per-stage terminal-count flags.
REQ-013 SHALL have port RCO, output, 1: chain ripple carry/borrow.

Function
REQ-014 SHALL register Cen as last_cen every Clk; tick = Cen & ~last_cen; nothing changes without a tick.
REQ-015 SHALL give on a tick the priority Clear_bar low (Q = 0) > Load_bar low (Q = D) > count (ENT & ENP) > hold.
REQ-016 SHALL update Q on the Clk edge that detects the tick; no added latency.
REQ-017 SHALL define stage terminal as digit == max (15, or 9 if BCD) when Up_Dn = 1, and digit == 0 when Up_Dn = 0.
REQ-018 SHALL drive Stage_TC[k] combinationally from the stage-k terminal condition, independent of ENT.
REQ-019 SHALL, on a count tick, step stage 0 and step stage k>0 only if Stage_TC[0..k-1] are all 1.
REQ-020 SHALL step up from max to 0 and down from 0 to max, wrapping the whole chain, e.g. all-max up -> all-zero.
REQ-021 SHALL, in BCD, load digits >9 unchanged; up from a digit >9 goes to 0 with no carry out of that stage; down from a digit >9 decrements normally.
REQ-022 SHALL drive RCO = ENT & (AND of all Stage_TC) combinationally from current Q and Up_Dn.
REQ-023 SHALL ignore Up_Dn, D and the enables between ticks; only their values at the tick matter.
REQ-024 SHALL, when Clear_bar and Load_bar are low together, clear Q to 0.

Reset
REQ-025 SHALL, while Reset_bar is low, force Q = 0 and last_cen = 1 asynchronously; Stage_TC and RCO follow from Q.
REQ-026 SHALL not produce a tick on the first Clk after reset release when Cen is already high.
REQ-027 SHALL, on reset asserted mid-count, discard any pending tick; counting resumes from 0 on the next true rising edge of Cen.

Structure
REQ-028 SHALL place the stage width (4), binary max (15) and BCD max (9) constants in a shared package ttl_counter_pkg.
REQ-029 SHALL implement each digit as sub-module ttl_updn_stage_sync (one 4-bit up/down stage with BCD mode, step-in and terminal-out), instantiated STAGES times with a generate loop.
REQ-030 SHALL keep Cen edge detection in the top level, shared by all stages.

Verification (STAGES=2 unless noted)
REQ-031 SHALL cover binary up carry: load 0x0E, Up_Dn=1, 3 ticks -> Q 0x0F, 0x10, 0x11; Stage_TC[0]=1 only at 0x0F.
REQ-032 SHALL cover down wrap: Q=0x00, Up_Dn=0, ENT=1, RCO=1; 1 tick -> Q=0xFF, RCO=0.
REQ-033 SHALL cover BCD=1: Q=0x99, Up_Dn=1, RCO=1; 1 tick -> Q=0x00; load 0x0C then 1 tick up -> Q=0x00.
REQ-034 SHALL cover priority and gating: Clear_bar=0 with Load_bar=0 -> Q=0; ENP=0 -> Q holds; Cen held high 10 Clk -> exactly 1 tick.
REQ-035 SHALL cover reset: Reset_bar low mid-count at Q=0x37 -> Q=0 immediately; release with Cen high -> no tick until Cen falls and rises again.
REQ-036 SHALL cover STAGES=4: Q=0xFFFF, Up_Dn=1, 1 tick -> Q=0x0000 with RCO falling from 1 to 0.

Source files
------------

// File: rtl/ttl_updn_counter_chain_sync_pkg.sv
// Shared constants for the cascaded 4-bit up/down counter chain.
package ttl_counter_pkg;

  localparam int STAGE_W = 4;
  localparam logic [STAGE_W-1:0] BIN_MAX = 4'd15;
  localparam logic [STAGE_W-1:0] BCD_MAX = 4'd9;

  function automatic logic [STAGE_W-1:0] digit_max(input int bcd);
    return (bcd != 0) ? BCD_MAX : BIN_MAX;
  endfunction

endpackage

// File: rtl/ttl_updn_counter_chain_sync_if.sv
// Control, data and status bundle of the counter chain.
interface ttl_updn_counter_chain_sync_if #(
  parameter int STAGES = 2
);
  logic                  Cen;
  logic                  Clear_bar;
  logic                  Load_bar;
  logic                  ENT;
  logic                  ENP;
  logic                  Up_Dn;
  logic [4*STAGES-1:0]   D;
  logic [4*STAGES-1:0]   Q;
  logic [STAGES-1:0]     Stage_TC;
  logic                  RCO;

  modport master (
    output Cen, Clear_bar, Load_bar, ENT, ENP, Up_Dn, D,
    input  Q, Stage_TC, RCO
  );

  modport slave (
    input  Cen, Clear_bar, Load_bar, ENT, ENP, Up_Dn, D,
    output Q, Stage_TC, RCO
  );
endinterface

// File: rtl/ttl_updn_counter_chain_sync_stage.sv
// One 4-bit up/down digit; clr/ld/step arrive already qualified by the tick.
module ttl_updn_stage_sync
  import ttl_counter_pkg::*;
#(
  parameter int BCD = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               ld,
  input  logic               step,
  input  logic               up,
  input  logic [STAGE_W-1:0] d,
  output logic [STAGE_W-1:0] q,
  output logic               tc
);

  localparam logic [STAGE_W-1:0] MAX = digit_max(BCD);

  logic [STAGE_W-1:0] q_next;

  always_comb begin
    tc = up ? (q == MAX) : (q == '0);
  end

  // Up from an out-of-range BCD digit (>9) returns to 0; tc stays low so no carry.
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (ld) begin
      q_next = d;
    end else if (step) begin
      if (up) begin
        q_next = (q >= MAX) ? '0 : q + STAGE_W'(1);
      end else begin
        q_next = (q == '0) ? MAX : q - STAGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/ttl_updn_counter_chain_sync.sv
// Cascaded up/down counter chain; one Cen rising edge = one tick for all stages.
module ttl_updn_counter_chain_sync
  import ttl_counter_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int BCD    = 0
) (
  input  logic                          Clk,
  input  logic                          Reset_bar,
  ttl_updn_counter_chain_sync_if.slave  bus
);

  logic                        last_cen;
  logic                        tick;
  logic                        do_clr;
  logic                        do_ld;
  logic                        do_cnt;
  logic [STAGES-1:0]           tc;
  logic [STAGES-1:0]           carry;
  logic [STAGE_W*STAGES-1:0]   q_all;

  // Reset value 1 blocks a false tick when Cen is already high at release.
  always_ff @(posedge Clk or negedge Reset_bar) begin
    if (!Reset_bar) begin
      last_cen <= 1'b1;
    end else begin
      last_cen <= bus.Cen;
    end
  end

  always_comb begin
    tick   = bus.Cen & ~last_cen;
    do_clr = tick & ~bus.Clear_bar;
    do_ld  = tick & bus.Clear_bar & ~bus.Load_bar;
    do_cnt = tick & bus.Clear_bar & bus.Load_bar & bus.ENT & bus.ENP;
  end

  always_comb begin : carry_chain
    logic acc;
    acc   = 1'b1;
    carry = '0;
    for (int k = 0; k < STAGES; k++) begin
      carry[k] = acc;
      acc      = acc & tc[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ttl_updn_stage_sync #(
      .BCD (BCD)
    ) u_stage (
      .clk   (Clk),
      .rst_n (Reset_bar),
      .clr   (do_clr),
      .ld    (do_ld),
      .step  (do_cnt & carry[k]),
      .up    (bus.Up_Dn),
      .d     (bus.D[STAGE_W*k +: STAGE_W]),
      .q     (q_all[STAGE_W*k +: STAGE_W]),
      .tc    (tc[k])
    );
  end

  assign bus.Q        = q_all;
  assign bus.Stage_TC = tc;
  assign bus.RCO      = bus.ENT & (&tc);

endmodule

// File: tb/tb_ttl_updn_counter_chain_sync.sv
// Scoreboard bench for binary, BCD and 4-stage builds of the counter chain.
module tb_ttl_updn_counter_chain_sync;

  logic Clk = 1'b0;
  logic Reset_bar = 1'b0;
  logic cen = 1'b0;

  always #5 Clk = ~Clk;

  ttl_updn_counter_chain_sync_if #(.STAGES(2)) b_if ();
  ttl_updn_counter_chain_sync_if #(.STAGES(2)) c_if ();
  ttl_updn_counter_chain_sync_if #(.STAGES(4)) w_if ();

  assign b_if.Cen = cen;
  assign c_if.Cen = cen;
  assign w_if.Cen = cen;

  ttl_updn_counter_chain_sync #(.STAGES(2), .BCD(0)) dut_bin (
    .Clk (Clk), .Reset_bar (Reset_bar), .bus (b_if));
  ttl_updn_counter_chain_sync #(.STAGES(2), .BCD(1)) dut_bcd (
    .Clk (Clk), .Reset_bar (Reset_bar), .bus (c_if));
  ttl_updn_counter_chain_sync #(.STAGES(4), .BCD(0)) dut_wide (
    .Clk (Clk), .Reset_bar (Reset_bar), .bus (w_if));

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] sb[$];
  logic [15:0] e;

  // One clean rising edge of Cen; returns 1 time unit after the ticking edge.
  task automatic pulse();
    @(negedge Clk) cen = 1'b0;
    @(negedge Clk) cen = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    b_if.Up_Dn = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    n_total++;
    if (b_if.Q !== 8'h00) $display("FAIL reset_q got=%h exp=00", b_if.Q); else n_pass++;
    n_total++;
    if (b_if.Stage_TC !== 2'b11) $display("FAIL reset_tc got=%b exp=11", b_if.Stage_TC); else n_pass++;
    n_total++;
    if (b_if.RCO !== 1'b1) $display("FAIL reset_rco got=%b exp=1", b_if.RCO); else n_pass++;
    n_total++;
    if (w_if.Q !== 16'h0000) $display("FAIL reset_wide_q got=%h exp=0000", w_if.Q); else n_pass++;
    @(negedge Clk) Reset_bar = 1'b1;
  endtask

  task automatic test_bin_up_carry();
    b_if.Up_Dn = 1'b1; b_if.D = 8'h0E; b_if.Load_bar = 1'b0;
    sb.push_back(16'h000E);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL load_0e got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
    b_if.Load_bar = 1'b1;
    #1;
    n_total++;
    if (b_if.Stage_TC[0] !== 1'b0) $display("FAIL tc0_at_0e got=%b exp=0", b_if.Stage_TC[0]); else n_pass++;
    sb.push_back(16'h000F); sb.push_back(16'h0010); sb.push_back(16'h0011);
    for (int i = 0; i < 3; i++) begin
      pulse();
      e = sb.pop_front();
      n_total++;
      if (b_if.Q !== e[7:0]) $display("FAIL up_carry_q step=%0d got=%h exp=%h", i, b_if.Q, e[7:0]);
      else n_pass++;
      n_total++;
      if (b_if.Stage_TC[0] !== (e[3:0] == 4'hF))
        $display("FAIL up_carry_tc0 step=%0d got=%b exp=%b", i, b_if.Stage_TC[0], (e[3:0] == 4'hF));
      else n_pass++;
    end
  endtask

  task automatic test_down_wrap();
    b_if.Clear_bar = 1'b0;
    sb.push_back(16'h0000);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL clear got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
    b_if.Clear_bar = 1'b1; b_if.Up_Dn = 1'b0;
    #1;
    n_total++;
    if (b_if.RCO !== 1'b1) $display("FAIL down_rco_before got=%b exp=1", b_if.RCO); else n_pass++;
    sb.push_back(16'h00FF);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL down_wrap got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
    n_total++;
    if (b_if.RCO !== 1'b0) $display("FAIL down_rco_after got=%b exp=0", b_if.RCO); else n_pass++;
  endtask

  task automatic test_priority_gating();
    b_if.Clear_bar = 1'b0; b_if.Load_bar = 1'b0; b_if.D = 8'h55;
    sb.push_back(16'h0000);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL clear_over_load got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
    b_if.Clear_bar = 1'b1; b_if.D = 8'h42;
    sb.push_back(16'h0042);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL load_42 got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
    b_if.Load_bar = 1'b1; b_if.Up_Dn = 1'b1; b_if.ENP = 1'b0;
    sb.push_back(16'h0042);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL enp_hold got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
    b_if.ENP = 1'b1; b_if.ENT = 1'b0;
    sb.push_back(16'h0042);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL ent_hold got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
    b_if.ENT = 1'b1;
    sb.push_back(16'h0043);
    @(negedge Clk) cen = 1'b0;
    @(negedge Clk) cen = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL cen_held_one_tick got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
  endtask

  task automatic test_ignore_between_ticks();
    b_if.Up_Dn = 1'b0; b_if.D = 8'hAA; b_if.Load_bar = 1'b0; b_if.Clear_bar = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_total++;
    if (b_if.Q !== 8'h43) $display("FAIL no_tick_hold got=%h exp=43", b_if.Q); else n_pass++;
    b_if.Up_Dn = 1'b1; b_if.Load_bar = 1'b1; b_if.Clear_bar = 1'b1;
    sb.push_back(16'h0044);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL tick_values_only got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    b_if.D = 8'h37; b_if.Load_bar = 1'b0;
    sb.push_back(16'h0037);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL load_37 got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
    b_if.Load_bar = 1'b1;
    @(posedge Clk);
    #2 Reset_bar = 1'b0;
    #1;
    n_total++;
    if (b_if.Q !== 8'h00) $display("FAIL async_reset got=%h exp=00", b_if.Q); else n_pass++;
    @(negedge Clk) Reset_bar = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    n_total++;
    if (b_if.Q !== 8'h00) $display("FAIL no_tick_after_release got=%h exp=00", b_if.Q); else n_pass++;
    sb.push_back(16'h0001);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (b_if.Q !== e[7:0]) $display("FAIL resume_after_reset got=%h exp=%h", b_if.Q, e[7:0]); else n_pass++;
  endtask

  task automatic test_bcd();
    c_if.Up_Dn = 1'b1; c_if.D = 8'h99; c_if.Load_bar = 1'b0;
    sb.push_back(16'h0099);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (c_if.Q !== e[7:0]) $display("FAIL bcd_load_99 got=%h exp=%h", c_if.Q, e[7:0]); else n_pass++;
    c_if.Load_bar = 1'b1;
    #1;
    n_total++;
    if (c_if.RCO !== 1'b1) $display("FAIL bcd_rco_99 got=%b exp=1", c_if.RCO); else n_pass++;
    sb.push_back(16'h0000);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (c_if.Q !== e[7:0]) $display("FAIL bcd_wrap got=%h exp=%h", c_if.Q, e[7:0]); else n_pass++;
    n_total++;
    if (c_if.RCO !== 1'b0) $display("FAIL bcd_rco_00 got=%b exp=0", c_if.RCO); else n_pass++;
    c_if.D = 8'h0C; c_if.Load_bar = 1'b0;
    sb.push_back(16'h000C); sb.push_back(16'h0000);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (c_if.Q !== e[7:0]) $display("FAIL bcd_load_0c got=%h exp=%h", c_if.Q, e[7:0]); else n_pass++;
    c_if.Load_bar = 1'b1;
    pulse();
    e = sb.pop_front();
    n_total++;
    if (c_if.Q !== e[7:0]) $display("FAIL bcd_up_from_c got=%h exp=%h", c_if.Q, e[7:0]); else n_pass++;
    c_if.D = 8'h0C; c_if.Load_bar = 1'b0;
    pulse();
    c_if.Load_bar = 1'b1; c_if.Up_Dn = 1'b0;
    sb.push_back(16'h000B);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (c_if.Q !== e[7:0]) $display("FAIL bcd_down_from_c got=%h exp=%h", c_if.Q, e[7:0]); else n_pass++;
    c_if.D = 8'h19; c_if.Load_bar = 1'b0;
    pulse();
    c_if.Load_bar = 1'b1; c_if.Up_Dn = 1'b1;
    sb.push_back(16'h0020);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (c_if.Q !== e[7:0]) $display("FAIL bcd_carry_19 got=%h exp=%h", c_if.Q, e[7:0]); else n_pass++;
  endtask

  task automatic test_wide();
    w_if.Up_Dn = 1'b1; w_if.D = 16'hFFFF; w_if.Load_bar = 1'b0;
    sb.push_back(16'hFFFF);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (w_if.Q !== e) $display("FAIL wide_load got=%h exp=%h", w_if.Q, e); else n_pass++;
    w_if.Load_bar = 1'b1;
    #1;
    n_total++;
    if (w_if.RCO !== 1'b1) $display("FAIL wide_rco_before got=%b exp=1", w_if.RCO); else n_pass++;
    sb.push_back(16'h0000);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (w_if.Q !== e) $display("FAIL wide_wrap got=%h exp=%h", w_if.Q, e); else n_pass++;
    n_total++;
    if (w_if.RCO !== 1'b0) $display("FAIL wide_rco_after got=%b exp=0", w_if.RCO); else n_pass++;
    w_if.D = 16'h1000; w_if.Load_bar = 1'b0;
    pulse();
    w_if.Load_bar = 1'b1; w_if.Up_Dn = 1'b0;
    sb.push_back(16'h0FFF);
    pulse();
    e = sb.pop_front();
    n_total++;
    if (w_if.Q !== e) $display("FAIL wide_borrow got=%h exp=%h", w_if.Q, e); else n_pass++;
  endtask

  initial begin
    foreach (sb[i]) sb.delete(i);
    b_if.Clear_bar = 1'b1; b_if.Load_bar = 1'b1; b_if.ENT = 1'b1; b_if.ENP = 1'b1;
    b_if.Up_Dn = 1'b1; b_if.D = '0;
    c_if.Clear_bar = 1'b1; c_if.Load_bar = 1'b1; c_if.ENT = 1'b1; c_if.ENP = 1'b1;
    c_if.Up_Dn = 1'b1; c_if.D = '0;
    w_if.Clear_bar = 1'b1; w_if.Load_bar = 1'b1; w_if.ENT = 1'b1; w_if.ENP = 1'b1;
    w_if.Up_Dn = 1'b1; w_if.D = '0;
    test_reset();
    test_bin_up_carry();
    test_down_wrap();
    test_priority_gating();
    test_ignore_between_ticks();
    test_reset_mid();
    test_bcd();
    test_wide();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
